buffer_reader: RTL and testbench

Read-side controller for the multi-port circular buffer. It owns both buffer pointers and tracks occupancy. It grants K-element write commits to the producer and drains the buffer J elements at a time into a registered valid/ready output stage. It sits between the buffer's `par_out`/`read_add`/`write_add`/`ld` pins and the downstream consumer.

---
 rtl/buffer_reader.sv | 127 ++++++++++++
 tb/tb_buffer_reader.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/buffer_reader.sv
// buffer_reader: read-side controller for the multi-port circular buffer.
// Owns the write/read pointers, tracks occupancy, grants K-element commits and
// drains J-element groups into a registered valid/ready output stage.
// Optional feature macro: BUFFER_READER_ERR_EN (sticky overflow error flag).
module buffer_reader #(
   parameter int SIZE  = 16,
   parameter int WIDTH = 8,
   parameter int K     = 4,
   parameter int J     = 4,
   parameter int BIT   = $clog2(SIZE)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 wr_commit,
   output logic                 wr_ready,
   output logic                 ld,
   output logic [BIT-1:0]       write_add,
   output logic [BIT-1:0]       read_add,
   input  logic [J*WIDTH-1:0]   buf_data,
   output logic [J*WIDTH-1:0]   out_data,
   output logic                 out_valid,
   input  logic                 out_ready,
   input  logic                 flush,
   output logic [BIT:0]         count,
   output logic                 err
);

   localparam logic [BIT:0]   SIZE_C = (BIT+1)'(SIZE);
   localparam logic [BIT:0]   K_C    = (BIT+1)'(K);
   localparam logic [BIT:0]   J_C    = (BIT+1)'(J);
   localparam logic [BIT-1:0] K_P    = BIT'(K);
   localparam logic [BIT-1:0] J_P    = BIT'(J);

   typedef enum logic {ST_EMPTY, ST_FULL} state_e;

   state_e               state_q, state_d;
   logic [BIT-1:0]       wr_ptr_q, wr_ptr_d;
   logic [BIT-1:0]       rd_ptr_q, rd_ptr_d;
   logic [BIT:0]         count_q, count_d;
   logic [J*WIDTH-1:0]   data_q, data_d;
   logic [BIT:0]         space;
   logic                 stage_free;
   logic                 fire;

   // Handshake decode: commit grant and group fire, both from registered count
   always_comb begin
      space      = SIZE_C - count_q;
      wr_ready   = !flush && (space >= K_C);
      // ld stays low while reset is asserted, even if a commit is requested
      ld         = wr_commit && wr_ready && rst;
      stage_free = (state_q == ST_EMPTY) || out_ready;
      fire       = !flush && (count_q >= J_C) && stage_free;
   end

   // Output stage state register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state_q <= ST_EMPTY;
      else      state_q <= state_d;
   end

   // Output stage next state: flush beats fire beats acceptance
   always_comb begin
      state_d = state_q;
      if (flush)                                  state_d = ST_EMPTY;
      else if (fire)                              state_d = ST_FULL;
      else if (state_q == ST_FULL && out_ready)   state_d = ST_EMPTY;
   end

   // Output stage outputs
   always_comb begin
      out_valid = (state_q == ST_FULL);
   end

   // Pointer, occupancy and output data next-state
   always_comb begin
      wr_ptr_d = ld ? wr_ptr_q + K_P : wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q + (ld ? K_C : '0) - (fire ? J_C : '0);
      data_d   = fire ? buf_data : data_q;
      if (flush) begin
         rd_ptr_d = wr_ptr_q;
         count_d  = '0;
      end else if (fire) begin
         rd_ptr_d = rd_ptr_q + J_P;
      end
   end

   // Datapath registers
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         data_q   <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         data_q   <= data_d;
      end
   end

   assign write_add = wr_ptr_q;
   assign read_add  = rd_ptr_q;
   assign count     = count_q;
   assign out_data  = data_q;

`ifdef BUFFER_READER_ERR_EN
   logic err_q, err_d;

   // Sticky overflow: a commit refused for lack of space, flush cycles excluded
   always_comb begin
      err_d = err_q || (wr_commit && !wr_ready && !flush);
   end

   // Error flag register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) err_q <= 1'b0;
      else      err_q <= err_d;
   end

   assign err = err_q;
`else
   assign err = 1'b0;
`endif

endmodule

// File: tb/tb_buffer_reader.sv
// Testbench for buffer_reader: random commit/flush/out_ready traffic checked
// against a queue-based model of buffer occupancy and output stage contents.
module tb_buffer_reader;
   localparam int SIZE  = 16;
   localparam int WIDTH = 8;
   localparam int K     = 4;
   localparam int J     = 4;
   localparam int BIT   = 4;

   logic                 clk = 1'b0;
   logic                 rst;
   logic                 wr_commit;
   logic                 wr_ready;
   logic                 ld;
   logic [BIT-1:0]       write_add;
   logic [BIT-1:0]       read_add;
   logic [J*WIDTH-1:0]   buf_data;
   logic [J*WIDTH-1:0]   out_data;
   logic                 out_valid;
   logic                 out_ready;
   logic                 flush;
   logic [BIT:0]         count;
   logic                 err;

   int n_vec = 0;
   int n_bad = 0;

   // Buffer storage emulated by the bench; par_out follows read_add
   logic [WIDTH-1:0] mem [SIZE];

   // Reference model state
   logic [WIDTH-1:0]   q [$];
   int                 m_wptr, m_rptr;
   bit                 m_vld, m_err;
   logic [J*WIDTH-1:0] m_data;

   buffer_reader #(
      .SIZE(SIZE), .WIDTH(WIDTH), .K(K), .J(J), .BIT(BIT)
   ) dut (
      .clk(clk), .rst(rst), .wr_commit(wr_commit), .wr_ready(wr_ready),
      .ld(ld), .write_add(write_add), .read_add(read_add),
      .buf_data(buf_data), .out_data(out_data), .out_valid(out_valid),
      .out_ready(out_ready), .flush(flush), .count(count), .err(err)
   );

   always #5 clk = ~clk;

   always_comb begin
      buf_data = '0;
      for (int i = 0; i < J; i++)
         buf_data[i*WIDTH +: WIDTH] = mem[(int'(read_add) + i) % SIZE];
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      q.delete();
      m_wptr = 0;
      m_rptr = 0;
      m_vld  = 1'b0;
      m_err  = 1'b0;
      m_data = '0;
   endtask

   // One clock cycle: drive, check combinational grant, advance model, check state
   task automatic step(input bit c, input bit f, input bit r);
      bit e_rdy, e_ld, e_fire;
      logic [WIDTH-1:0] v;
      @(negedge clk);
      wr_commit = c;
      flush     = f;
      out_ready = r;
      #1;
      e_rdy  = !f && ((SIZE - q.size()) >= K);
      e_ld   = c && e_rdy;
      e_fire = !f && (q.size() >= J) && (!m_vld || r);
      check("wr_ready", 64'(wr_ready), 64'(e_rdy));
      check("ld", 64'(ld), 64'(e_ld));
`ifdef BUFFER_READER_ERR_EN
      if (c && !e_rdy && !f) m_err = 1'b1;
`endif
      if (f) begin
         q.delete();
         m_vld  = 1'b0;
         m_rptr = m_wptr;
      end else begin
         if (e_fire) begin
            for (int i = 0; i < J; i++) m_data[i*WIDTH +: WIDTH] = q.pop_front();
            m_rptr = (m_rptr + J) % SIZE;
            m_vld  = 1'b1;
         end else if (m_vld && r) begin
            m_vld = 1'b0;
         end
         if (e_ld) begin
            for (int i = 0; i < K; i++) begin
               v = WIDTH'($urandom);
               mem[(m_wptr + i) % SIZE] = v;
               q.push_back(v);
            end
            m_wptr = (m_wptr + K) % SIZE;
         end
      end
      @(posedge clk);
      #1;
      check("count", 64'(count), 64'(q.size()));
      check("write_add", 64'(write_add), 64'(m_wptr));
      check("read_add", 64'(read_add), 64'(m_rptr));
      check("out_valid", 64'(out_valid), 64'(m_vld));
      if (m_vld) check("out_data", 64'(out_data), 64'(m_data));
      check("err", 64'(err), 64'(m_err));
   endtask

   task automatic check_reset_values();
      check("rst_write_add", 64'(write_add), 64'd0);
      check("rst_read_add", 64'(read_add), 64'd0);
      check("rst_count", 64'(count), 64'd0);
      check("rst_out_valid", 64'(out_valid), 64'd0);
      check("rst_out_data", 64'(out_data), 64'd0);
      check("rst_err", 64'(err), 64'd0);
      check("rst_wr_ready", 64'(wr_ready), 64'd1);
      check("rst_ld", 64'(ld), 64'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      for (int i = 0; i < SIZE; i++) mem[i] = '0;
      model_reset();
      rst       = 1'b0;
      wr_commit = 1'b1;
      flush     = 1'b0;
      out_ready = 1'b0;
      #12;
      check_reset_values();
      @(negedge clk);
      rst       = 1'b1;
      wr_commit = 1'b0;

      // Single commit then fire
      step(1, 0, 1);
      step(0, 0, 1);
      step(0, 0, 1);

      // Fill with consumer stalled, then one overflowing commit
      for (int i = 0; i < 6; i++) step(1, 0, 0);
      for (int i = 0; i < 6; i++) step(0, 0, 1);

      // Simultaneous commit and fire at count 8
      step(1, 0, 0);
      step(1, 0, 0);
      step(1, 0, 0);
      step(1, 0, 1);
      step(1, 0, 1);

      // Flush with data held and a commit pending
      step(1, 1, 0);
      step(0, 0, 1);

      // Random traffic, includes pointer wrap and occasional flushes
      for (int n = 0; n < 600; n++)
         step($urandom_range(0, 99) < 60, $urandom_range(0, 99) < 4,
              $urandom_range(0, 99) < 70);

      // Asynchronous reset mid-transfer with count 8 and a held group
      step(0, 1, 0);
      step(1, 0, 0);
      step(1, 0, 0);
      step(1, 0, 0);
      check("pre_rst_count", 64'(count), 64'd8);
      check("pre_rst_valid", 64'(out_valid), 64'd1);
      @(posedge clk);
      #2;
      wr_commit = 1'b1;
      rst       = 1'b0;
      #1;
      check_reset_values();
      model_reset();
      @(negedge clk);
      rst       = 1'b1;
      wr_commit = 1'b0;

      for (int n = 0; n < 300; n++)
         step($urandom_range(0, 99) < 50, $urandom_range(0, 99) < 3,
              $urandom_range(0, 99) < 50);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end
endmodule
